// File: rtl/usb_ls_pkg.sv
// Shared definitions for the low-speed USB receive path.
//   LS_J / LS_K / LS_SE0  : synchronised {dp,dm} line-state encodings
//   rx_state_t            : receiver FSM states
//   CRC16_POLY/RESIDUE    : USB data CRC16 generator and good-packet residue
//   PID_DATA0 / PID_DATA1 : data packet identifiers
//   crc16_step            : one serial CRC16 update, LSB-first bit stream
package usb_ls_pkg;

  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (USB data CRC) accumulator.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : preset register to all ones
//   bit_en       : advance the CRC by one bit
//   bit_in       : data bit (bits arrive LSB-first per byte)
//   crc          : current register contents
module usb_crc16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  import usb_ls_pkg::*;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    crc <= '1;
    else if (clear)  crc <= '1;
    else if (bit_en) crc <= crc16_step(crc, bit_in);
  end

endmodule

// File: rtl/usb_ls_rx.sv
// Low-speed USB receiver front-end, 8x oversampled from the 12 MHz PLL clock.
// Synchronises D+/D-, recovers bit timing, detects SYNC, NRZI-decodes,
// destuffs, assembles LSB-first bytes and detects EOP.
//   clk, reset_n : 12 MHz clock, asynchronous active-low reset
//   rx_en        : receiver enable; low forces IDLE and discards the packet
//   dp, dm       : asynchronous pad inputs
//   rx_data      : received byte, valid with rx_valid
//   rx_valid     : 1-cycle byte strobe
//   rx_active    : high from SYNC accept to EOP / abort
//   rx_eop       : 1-cycle end-of-packet strobe
//   rx_err       : 1-cycle stuff-error or partial-byte strobe
//   line_state   : synchronised {dp,dm}
//   rx_crc_ok    : CRC16 residue check, valid with rx_eop
// Build option: define USB_LS_RX_CRC_EN to include the CRC16 checker;
// otherwise rx_crc_ok is tied low.
module usb_ls_rx #(
  parameter int OVERSAMPLE    = 8,
  parameter int SAMPLE_PHASE  = 4,
  parameter int SYNC_MIN_ZERO = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       dp,
  input  logic       dm,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_err,
  output logic [1:0] line_state,
  output logic       rx_crc_ok
);
  import usb_ls_pkg::*;

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic          dp_meta, dm_meta;
  logic [1:0]    ls_prev;
  logic [PW-1:0] phase, phase_eff;
  logic          ls_j, ls_k, is_jk, jk_edge, sample, dec, stuff_slot, sync_ok, eop_end;

  rx_state_t     state;
  logic [1:0]    prev_sym;
  logic [3:0]    zero_cnt;
  logic [2:0]    ones_cnt, bit_cnt, se0_cnt;
  logic [7:0]    shreg;
  logic          seen_se0;

  // Synchroniser resets to J so the idle bus looks idle straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_meta    <= 1'b0;
      dm_meta    <= 1'b1;
      line_state <= LS_J;
      ls_prev    <= LS_J;
      phase      <= '0;
    end else begin
      dp_meta    <= dp;
      dm_meta    <= dm;
      line_state <= {dp_meta, dm_meta};
      ls_prev    <= line_state;
      phase      <= (phase_eff == PW'(OVERSAMPLE - 1)) ? '0 : phase_eff + 1'b1;
    end
  end

  always_comb begin
    ls_j       = (line_state == LS_J);
    ls_k       = (line_state == LS_K);
    is_jk      = ls_j | ls_k;
    // Only J<->K transitions realign; SE0 edges carry no bit timing.
    jk_edge    = (ls_j && ls_prev == LS_K) || (ls_k && ls_prev == LS_J);
    phase_eff  = jk_edge ? '0 : phase;
    sample     = (phase_eff == PW'(SAMPLE_PHASE));
    dec        = (line_state == prev_sym);
    stuff_slot = (ones_cnt == 3'd6);
    sync_ok    = (zero_cnt >= 4'(SYNC_MIN_ZERO));
    // Packet end: J after SE0, or the fifth consecutive SE0 sample (bus reset).
    eop_end    = rx_en && sample && (state == EOP) &&
                 (ls_j || (!is_jk && se0_cnt == 3'd4));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prev_sym  <= LS_J;
      zero_cnt  <= '0;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      se0_cnt   <= '0;
      shreg     <= '0;
      seen_se0  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_eop    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_err   <= 1'b0;
      if (!rx_en) begin
        state     <= IDLE;
        prev_sym  <= LS_J;
        rx_active <= 1'b0;
        zero_cnt  <= '0;
        ones_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (sample) begin
        unique case (state)
          IDLE: begin
            if (ls_k) begin
              state    <= SYNC;
              prev_sym <= LS_K;
              zero_cnt <= 4'd1;   // first K against idle J decodes as 0
            end
          end
          SYNC: begin
            if (!is_jk) begin
              state    <= IDLE;
              prev_sym <= LS_J;
            end else begin
              prev_sym <= line_state;
              if (!dec) begin
                if (zero_cnt != 4'hF) zero_cnt <= zero_cnt + 4'd1;
              end else if (sync_ok) begin
                state     <= DATA;
                rx_active <= 1'b1;
                ones_cnt  <= '0;
                bit_cnt   <= '0;
              end else begin
                state    <= IDLE;
                prev_sym <= LS_J;
              end
            end
          end
          DATA: begin
            if (!is_jk) begin
              state   <= EOP;
              se0_cnt <= 3'd1;
            end else begin
              prev_sym <= line_state;
              if (stuff_slot) begin
                if (dec) begin
                  state     <= ERR;
                  rx_err    <= 1'b1;
                  rx_active <= 1'b0;
                  seen_se0  <= 1'b0;
                end else begin
                  ones_cnt <= '0;
                end
              end else begin
                ones_cnt <= dec ? ones_cnt + 3'd1 : 3'd0;
                shreg    <= {dec, shreg[7:1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  rx_data  <= {dec, shreg[7:1]};
                  rx_valid <= 1'b1;
                end
              end
            end
          end
          EOP: begin
            if (eop_end) begin
              state     <= IDLE;
              prev_sym  <= LS_J;
              rx_eop    <= 1'b1;
              rx_active <= 1'b0;
              rx_err    <= (bit_cnt != 3'd0);
            end else if (!is_jk) begin
              se0_cnt <= se0_cnt + 3'd1;
            end
          end
          ERR: begin
            if (!is_jk) begin
              seen_se0 <= 1'b1;
            end else if (seen_se0 && ls_j) begin
              state    <= IDLE;
              prev_sym <= LS_J;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef USB_LS_RX_CRC_EN
  logic        crc_clr, crc_bit_en, pid_seen;
  logic [15:0] crc;

  assign crc_clr    = rx_en && sample && (state == SYNC) && is_jk && dec && sync_ok;
  assign crc_bit_en = rx_en && sample && (state == DATA) && is_jk && !stuff_slot && pid_seen;

  // The PID byte strobe arrives well before the next bit sample, so it
  // safely gates the CRC onto the bits that follow the PID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pid_seen <= 1'b0;
    else if (crc_clr)  pid_seen <= 1'b0;
    else if (rx_valid) pid_seen <= 1'b1;
  end

  usb_crc16 u_crc16 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clr),
    .bit_en  (crc_bit_en),
    .bit_in  (dec),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_crc_ok <= 1'b0;
    else          rx_crc_ok <= eop_end && (crc == CRC16_RESIDUE);
  end
`else
  assign rx_crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_usb_ls_rx.sv
// Self-checking bench for usb_ls_rx: builds logical packets, encodes them
// to NRZI wire symbols with stuffing, and compares received bytes/strobes
// against expectations derived from the logical bit list.
module tb_usb_ls_rx;
  import usb_ls_pkg::*;

`ifdef USB_LS_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, rx_en, dp, dm;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_err, rx_crc_ok;
  logic [1:0] line_state;

  usb_ls_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_en      (rx_en),
    .dp         (dp),
    .dm         (dm),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .rx_eop     (rx_eop),
    .rx_err     (rx_err),
    .line_state (line_state),
    .rx_crc_ok  (rx_crc_ok)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  logic       bits_q[$];
  logic [1:0] wire_q[$];
  logic [7:0] got_q[$];
  int         eop_n, err_n, both_n, clash_n;
  logic       crc_seen, err_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (rx_eop) begin eop_n++; crc_seen = rx_crc_ok; end
    if (rx_err) begin err_n++; err_active = rx_active; end
    if (rx_eop && rx_err) both_n++;
    if (rx_valid && rx_eop) clash_n++;
  end

  task automatic clear_mon();
    #2;
    got_q.delete();
    eop_n = 0; err_n = 0; both_n = 0; clash_n = 0;
    crc_seen = 1'b0; err_active = 1'b1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
  endtask

  // CRC over everything after the PID; sent inverted, high bit first.
  task automatic append_crc(input bit corrupt);
    logic [15:0] c;
    int          idx;
    c = '1;
    for (int i = 8; i < bits_q.size(); i++) c = crc16_step(c, bits_q[i]);
    for (int i = 15; i >= 0; i--) bits_q.push_back(~c[i]);
    if (corrupt) begin
      idx = $urandom_range(bits_q.size() - 1, 8);
      bits_q[idx] = ~bits_q[idx];
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == LS_J) ? LS_K : LS_J;
  endfunction

  task automatic encode(input bit stuff, input int se0_bits);
    logic [1:0] lvl;
    int         run;
    wire_q.delete();
    lvl = LS_J;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) lvl = flip(lvl);
      wire_q.push_back(lvl);
    end
    run = 0;
    foreach (bits_q[i]) begin
      if (!bits_q[i]) lvl = flip(lvl);
      wire_q.push_back(lvl);
      run = bits_q[i] ? run + 1 : 0;
      if (stuff && run == 6) begin
        lvl = flip(lvl);
        wire_q.push_back(lvl);
        run = 0;
      end
    end
    repeat (se0_bits) wire_q.push_back(LS_SE0);
    wire_q.push_back(LS_J);
  endtask

  task automatic send(input bit jitter, input int limit);
    for (int i = 0; i < wire_q.size() && i < limit; i++) begin
      {dp, dm} = wire_q[i];
      repeat (jitter ? ((i % 2) ? 9 : 7) : 8) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    {dp, dm} = LS_J;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_pkt(input bit jitter);
    clear_mon();
    @(negedge clk);
    send(jitter, 1 << 30);
    idle(48);
  endtask

  task automatic check_packet(input bit crc_added, input bit crc_good);
    int         nf;
    logic       part;
    logic [7:0] e;
    nf   = bits_q.size() / 8;
    part = (bits_q.size() % 8) != 0;
    check("nbytes", got_q.size(), nf);
    for (int i = 0; i < nf && i < got_q.size(); i++) begin
      for (int k = 0; k < 8; k++) e[k] = bits_q[8*i + k];
      check("byte", got_q[i], e);
    end
    check("eop", eop_n, 1);
    check("err", err_n, part);
    check("eop_err_same", both_n, part);
    check("valid_eop_clash", clash_n, 0);
    check("active_after", rx_active, 0);
    if (crc_added) check("crc_ok", crc_seen, CRC_ON && crc_good);
  endtask

  task automatic build_std(input logic [7:0] pid, input logic [7:0] a, input logic [7:0] b);
    bits_q.delete();
    add_byte(pid); add_byte(a); add_byte(b);
    append_crc(0);
  endtask

  initial begin
    logic corrupt;
    int   n;
    reset_n = 1'b0; rx_en = 1'b1; {dp, dm} = LS_J;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_active", rx_active, 0);
    check("rst_eop", rx_eop, 0);
    check("rst_err", rx_err, 0);
    check("rst_data", rx_data, 0);
    check("rst_crc", rx_crc_ok, 0);
    check("rst_line", line_state, LS_J);
    @(negedge clk); reset_n = 1'b1;
    idle(30);

    // Basic packet, then the same bits with 7/9 jitter.
    build_std(PID_DATA0, 8'h00, 8'hFF); encode(1, 2); run_pkt(0); check_packet(1, 1);
    run_pkt(1); check_packet(1, 1);
    // Six ones followed by an inserted stuff bit.
    build_std(PID_DATA0, 8'h3F, 8'h00); encode(1, 2); run_pkt(0); check_packet(1, 1);
    // Twelve bits then EOP: one byte plus a partial residue.
    bits_q.delete(); add_byte(PID_DATA0);
    bits_q.push_back(1); bits_q.push_back(0); bits_q.push_back(1); bits_q.push_back(1);
    encode(1, 2); run_pkt(0); check_packet(0, 0);
    // Long SE0 ends the packet through the bus-reset guard.
    build_std(PID_DATA1, 8'h5A, 8'hA5); encode(1, 7); run_pkt(0); check_packet(1, 1);

    // Stuff violation: no stuffing applied to C3 FF 00.
    bits_q.delete(); add_byte(PID_DATA0); add_byte(8'hFF); add_byte(8'h00);
    encode(0, 2); run_pkt(0);
    check("se_nbytes", got_q.size(), 1);
    if (got_q.size() > 0) check("se_byte", got_q[0], PID_DATA0);
    check("se_err", err_n, 1);
    check("se_eop", eop_n, 0);
    check("se_active_at_err", err_active, 0);
    build_std(PID_DATA1, 8'h12, 8'h34); encode(1, 2); run_pkt(0); check_packet(1, 1);

    // rx_en abort mid-byte.
    build_std(PID_DATA0, 8'hA5, 8'h5A); encode(1, 2);
    clear_mon(); @(negedge clk);
    send(0, 20);
    check("en_active_pre", rx_active, 1);
    rx_en = 1'b0;
    @(posedge clk); #1;
    check("en_active_post", rx_active, 0);
    @(negedge clk); rx_en = 1'b1;
    idle(60);
    check("en_nbytes", got_q.size(), 1);
    check("en_eop", eop_n, 0);
    check("en_err", err_n, 0);
    build_std(PID_DATA0, 8'h77, 8'h88); encode(1, 2); run_pkt(0); check_packet(1, 1);

    // Reset abort mid-byte.
    build_std(PID_DATA1, 8'hC6, 8'h39); encode(1, 2);
    clear_mon(); @(negedge clk);
    send(0, 20);
    check("rs_active_pre", rx_active, 1);
    reset_n = 1'b0;
    #1;
    check("rs_active_post", rx_active, 0);
    check("rs_line", line_state, LS_J);
    {dp, dm} = LS_J;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(60);
    check("rs_nbytes", got_q.size(), 1);
    check("rs_eop", eop_n, 0);
    check("rs_err", err_n, 0);
    build_std(PID_DATA1, 8'h01, 8'h80); encode(1, 2); run_pkt(0); check_packet(1, 1);

    // Randomised data packets, some with a corrupted bit.
    for (int p = 0; p < 12; p++) begin
      bits_q.delete();
      add_byte(($urandom_range(1, 0) != 0) ? PID_DATA1 : PID_DATA0);
      n = $urandom_range(6, 0);
      for (int i = 0; i < n; i++)
        add_byte(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
      corrupt = ($urandom_range(3, 0) == 0);
      append_crc(corrupt);
      encode(1, 2);
      run_pkt($urandom_range(1, 0) != 0);
      check_packet(1, !corrupt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
